serial_tx: RTL

SERIAL_TX -- requirements
Module: serial_tx

---
 rtl/serial_tx_if.sv | 29 ++
 rtl/serial_tx.sv | 100 ++++++++++
 2 files changed

// File: rtl/serial_tx_if.sv
// rtl/serial_tx_if.sv - load/ready handshake and serial line bundle for serial_tx.
interface serial_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             load;
    logic             ready;
    logic             Q;
    logic             busy;
    logic             done;

    modport master (
        output data_in,
        output load,
        input  ready,
        input  Q,
        input  busy,
        input  done
    );

    modport slave (
        input  data_in,
        input  load,
        output ready,
        output Q,
        output busy,
        output done
    );
endinterface

// File: rtl/serial_tx.sv
// rtl/serial_tx.sv - parallel-to-serial framer: start 0, WIDTH data bits LSB first, stop 1.
module serial_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic        CLK,
    input  logic        reset,
    serial_tx_if.slave  bus
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_TICK = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_BIT  = IW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CW-1:0]    r_tick;
    logic [CW-1:0]    w_tick_next;
    logic [IW-1:0]    r_idx;
    logic [IW-1:0]    w_idx_next;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_next;
    logic             r_q;
    logic             w_q_next;
    logic             w_accept;
    logic             w_bit_end;

    assign w_accept  = bus.load && (r_state == IDLE);
    assign w_bit_end = (r_tick == LAST_TICK);

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next_state = START;
            START:   if (w_bit_end) w_next_state = DATA;
            DATA:    if (w_bit_end && (r_idx == LAST_BIT)) w_next_state = STOP;
            STOP:    if (w_bit_end) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.ready = (r_state == IDLE);
        bus.busy  = (r_state != IDLE);
        bus.done  = (r_state == STOP) && w_bit_end;
        bus.Q     = r_q;
    end

    always_comb begin
        w_tick_next  = '0;
        w_idx_next   = '0;
        w_shift_next = r_shift;
        if (r_state != IDLE) begin
            w_tick_next = w_bit_end ? '0 : r_tick + CW'(1);
        end
        if (w_accept) begin
            w_shift_next = bus.data_in;
        end
        if (r_state == DATA) begin
            w_idx_next = r_idx;
            if (w_bit_end) begin
                w_idx_next   = (r_idx == LAST_BIT) ? '0 : r_idx + IW'(1);
                w_shift_next = r_shift >> 1;
            end
        end
    end

    // Q is registered from the next state so it changes on the same edge as the state.
    always_comb begin
        case (w_next_state)
            START:   w_q_next = 1'b0;
            DATA:    w_q_next = w_shift_next[0];
            default: w_q_next = 1'b1;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_tick  <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_q     <= 1'b1;
        end else begin
            r_tick  <= w_tick_next;
            r_idx   <= w_idx_next;
            r_shift <= w_shift_next;
            r_q     <= w_q_next;
        end
    end
endmodule
